// File: rtl/z80_pkg.sv
// Shared Z80 bus constants: opcode bytes used by the M1 decoder and the
// opcode injector, plus the injector state encoding and byte-select helper.
package z80_pkg;

  // Opcode bytes recognised or emitted on the Z80 data bus
  localparam logic [7:0] OP_JP     = 8'hC3;
  localparam logic [7:0] OP_PFX_CB = 8'hCB;
  localparam logic [7:0] OP_PFX_ED = 8'hED;
  localparam logic [7:0] OP_PFX_DD = 8'hDD;
  localparam logic [7:0] OP_PFX_FD = 8'hFD;
  localparam logic [7:0] OP_RETN2  = 8'h45;

  // Injector state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARMED = 3'd1;
  localparam logic [2:0] ST_OP    = 3'd2;
  localparam logic [2:0] ST_LO    = 3'd3;
  localparam logic [2:0] ST_HI    = 3'd4;

  // Byte presented on the data bus while the injector sits in a given state
  function automatic logic [7:0] inj_byte(input logic [2:0]  st,
                                          input logic [15:0] vec,
                                          input logic [7:0]  jp_op);
    logic [7:0] b;
    case (st)
      ST_OP:   b = jp_op;
      ST_LO:   b = vec[7:0];
      ST_HI:   b = vec[15:8];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/z80_cycle_detect.sv
// Z80 bus-cycle snooper: registers RD once and derives read start/end
// strobes. Refresh (RD high) and interrupt acknowledge (MREQ high) never
// qualify as read starts.
module z80_cycle_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic m1_n,
  input  logic mreq_n,
  input  logic rd_n,
  output logic read_start,
  output logic read_end,
  output logic m1_read,
  output logic cycle_active
);

  logic rd_q;

  // Delayed copy of RD used for edge detection; idles high like the bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= 1'b1;
    end else begin
      rd_q <= rd_n;
    end
  end

  assign read_start   = (~rd_n) & rd_q & (~mreq_n);
  assign read_end     = rd_n & (~rd_q);
  assign m1_read      = read_start & (~m1_n);
  assign cycle_active = (~mreq_n) & (~rd_n);

endmodule

// File: rtl/opcode_injector.sv
// Opcode injector: on a trap request, waits for the next fresh instruction
// fetch and feeds the CPU a 3-byte JP nn while holding off real memory, so
// the CPU lands in the trap handler without an NMI.
module opcode_injector
  import z80_pkg::*;
#(
  parameter logic [7:0] JP_OPCODE = OP_JP,
  parameter int         VECTOR_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                m1_n,
  input  logic                mreq_n,
  input  logic                rd_n,
  input  logic                new_isr,
  input  logic                trap_req,
  input  logic                trap_cancel,
  input  logic [VECTOR_W-1:0] trap_vector,
  output logic [7:0]          data_out,
  output logic                data_oe,
  output logic                mem_inhibit,
  output logic                busy,
  output logic                inject_done
);

  logic                read_start;
  logic                read_end;
  logic                m1_read;
  logic                cycle_active;

  logic [2:0]          state;
  logic [2:0]          next_state;
  logic [VECTOR_W-1:0] vector_q;
  logic                latch_vector;
  logic                done_next;
  logic                drive_en;

  z80_cycle_detect u_cycle_detect (
    .clk          (clk),
    .rst_n        (rst_n),
    .m1_n         (m1_n),
    .mreq_n       (mreq_n),
    .rd_n         (rd_n),
    .read_start   (read_start),
    .read_end     (read_end),
    .m1_read      (m1_read),
    .cycle_active (cycle_active)
  );

  // Next-state decode; cancel only affects a request that has not started
  always_comb begin
    next_state   = state;
    latch_vector = 1'b0;
    done_next    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (trap_cancel) begin
          next_state = ST_IDLE;
        end else if (trap_req) begin
          next_state   = ST_ARMED;
          latch_vector = 1'b1;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (trap_cancel) begin
          next_state = ST_IDLE;
        end else if (m1_read && new_isr) begin
          next_state = ST_OP;
        end else begin
          next_state = ST_ARMED;
        end
      end
      ST_OP: begin
        if (read_end) begin
          next_state = ST_LO;
        end else begin
          next_state = ST_OP;
        end
      end
      ST_LO: begin
        // An opcode fetch here means the CPU lost sync with us: give up
        if (m1_read) begin
          next_state = ST_IDLE;
        end else if (read_end) begin
          next_state = ST_HI;
        end else begin
          next_state = ST_LO;
        end
      end
      ST_HI: begin
        if (m1_read) begin
          next_state = ST_IDLE;
        end else if (read_end) begin
          next_state = ST_IDLE;
          done_next  = 1'b1;
        end else begin
          next_state = ST_HI;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // State, latched jump target, registered data byte and completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      vector_q    <= '0;
      data_out    <= 8'h00;
      inject_done <= 1'b0;
    end else begin
      state       <= next_state;
      inject_done <= done_next;
      data_out    <= inj_byte(next_state, vector_q[15:0], JP_OPCODE);
      if (latch_vector) begin
        vector_q <= trap_vector;
      end else begin
        vector_q <= vector_q;
      end
    end
  end

  // Drive only during a live read; operand bytes never go out on an M1 fetch
  always_comb begin
    drive_en = 1'b0;
    case (state)
      ST_OP:   drive_en = cycle_active;
      ST_LO:   drive_en = cycle_active & m1_n;
      ST_HI:   drive_en = cycle_active & m1_n;
      default: drive_en = 1'b0;
    endcase
  end

  assign data_oe     = drive_en;
  assign mem_inhibit = drive_en;
  assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_opcode_injector.sv
// Self-checking bench for opcode_injector: bus-cycle-level reference model
// (armed flag plus a queue of bytes still to inject) driven by directed
// scenarios and a randomized cycle mix.
module tb_opcode_injector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m1_n = 1'b1;
  logic        mreq_n = 1'b1;
  logic        rd_n = 1'b1;
  logic        new_isr = 1'b0;
  logic        trap_req = 1'b0;
  logic        trap_cancel = 1'b0;
  logic [15:0] trap_vector = 16'h0000;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        mem_inhibit;
  logic        busy;
  logic        inject_done;

  int checks = 0;
  int errors = 0;

  // reference model
  bit          m_armed = 1'b0;
  bit          m_hold = 1'b0;
  logic [15:0] m_vec = 16'h0000;
  logic [7:0]  m_q[$];

  opcode_injector #(.JP_OPCODE(8'hC3), .VECTOR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .m1_n(m1_n), .mreq_n(mreq_n), .rd_n(rd_n),
    .new_isr(new_isr), .trap_req(trap_req), .trap_cancel(trap_cancel),
    .trap_vector(trap_vector), .data_out(data_out), .data_oe(data_oe),
    .mem_inhibit(mem_inhibit), .busy(busy), .inject_done(inject_done)
  );

  always #5 clk = ~clk;

  function automatic bit model_busy();
    return m_armed || (m_q.size() > 0);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({data_out, data_oe, mem_inhibit, busy, inject_done} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs got dout=%h oe=%b inh=%b busy=%b done=%b want all zero",
               data_out, data_oe, mem_inhibit, busy, inject_done);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    m_armed = 1'b0; m_q.delete();
  endtask

  // Request a trap for one clk (or hold it), optionally with cancel
  task automatic arm(input logic [15:0] vec, input bit cancel, input bit hold);
    @(negedge clk);
    trap_req = 1'b1; trap_vector = vec; trap_cancel = cancel;
    m_hold = hold;
    @(posedge clk); #1;
    if (m_armed) begin
      if (cancel) m_armed = 1'b0;
    end else if (m_q.size() == 0 && !cancel) begin
      m_armed = 1'b1; m_vec = vec;
    end
    checks++;
    if (busy !== model_busy()) begin
      errors++;
      $display("FAIL arm_busy got %b want %b", busy, model_busy());
    end
    @(negedge clk);
    trap_cancel = 1'b0;
    if (!hold) trap_req = 1'b0;
  endtask

  task automatic cancel_req();
    @(negedge clk);
    trap_cancel = 1'b1;
    @(posedge clk); #1;
    if (m_armed) m_armed = 1'b0;
    checks++;
    if (busy !== model_busy()) begin
      errors++;
      $display("FAIL cancel_busy got %b want %b", busy, model_busy());
    end
    @(negedge clk);
    trap_cancel = 1'b0;
  endtask

  // One memory read (M1 fetch when m1=1); checks drive, byte and done pulse
  task automatic bus_read(input bit m1, input bit isr);
    bit         drv;
    bit         done_exp;
    logic [7:0] b;
    @(negedge clk);
    m1_n = ~m1; new_isr = isr; mreq_n = 1'b0; rd_n = 1'b0;
    drv = 1'b0; b = 8'h00; done_exp = 1'b0;
    if (m_q.size() > 0) begin
      if (m1) m_q.delete();
      else begin drv = 1'b1; b = m_q[0]; end
    end else if (m_armed && m1 && isr) begin
      m_armed = 1'b0;
      m_q.push_back(8'hC3); m_q.push_back(m_vec[7:0]); m_q.push_back(m_vec[15:8]);
      drv = 1'b1; b = 8'hC3;
    end
    @(posedge clk); #1;
    checks++;
    if (data_oe !== drv || mem_inhibit !== drv) begin
      errors++;
      $display("FAIL read_drive got oe=%b inh=%b want %b", data_oe, mem_inhibit, drv);
    end
    if (drv) begin
      checks++;
      if (data_out !== b) begin
        errors++;
        $display("FAIL read_byte got %h want %h", data_out, b);
      end
    end
    checks++;
    if (busy !== model_busy()) begin
      errors++;
      $display("FAIL read_busy got %b want %b", busy, model_busy());
    end
    @(negedge clk);
    rd_n = 1'b1; mreq_n = 1'b1; m1_n = 1'b1; new_isr = 1'b0;
    #1;
    checks++;
    if (data_oe !== 1'b0 || mem_inhibit !== 1'b0) begin
      errors++;
      $display("FAIL release_on_rd got oe=%b inh=%b want 0", data_oe, mem_inhibit);
    end
    @(posedge clk); #1;
    if (drv) begin
      void'(m_q.pop_front());
      done_exp = (m_q.size() == 0);
    end
    checks++;
    if (inject_done !== done_exp) begin
      errors++;
      $display("FAIL inject_done got %b want %b", inject_done, done_exp);
    end
    checks++;
    if (busy !== model_busy()) begin
      errors++;
      $display("FAIL end_busy got %b want %b", busy, model_busy());
    end
    if (done_exp) begin
      @(posedge clk); #1;
      if (m_hold && trap_req) begin
        m_armed = 1'b1; m_vec = trap_vector;
      end
      checks++;
      if (inject_done !== 1'b0 || busy !== model_busy()) begin
        errors++;
        $display("FAIL after_done got done=%b busy=%b want done=0 busy=%b",
                 inject_done, busy, model_busy());
      end
    end
  endtask

  // kind 0: refresh, 1: write, 2: interrupt acknowledge
  task automatic bus_other(input int kind);
    @(negedge clk);
    case (kind)
      0: begin m1_n = 1'b1; mreq_n = 1'b0; rd_n = 1'b1; end
      1: begin m1_n = 1'b1; mreq_n = 1'b0; rd_n = 1'b1; end
      default: begin m1_n = 1'b0; mreq_n = 1'b1; rd_n = 1'b1; end
    endcase
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (data_oe !== 1'b0 || mem_inhibit !== 1'b0 || busy !== model_busy()) begin
        errors++;
        $display("FAIL nonread_cycle%0d got oe=%b inh=%b busy=%b want 0 0 %b",
                 kind, data_oe, mem_inhibit, busy, model_busy());
      end
    end
    @(negedge clk);
    m1_n = 1'b1; mreq_n = 1'b1; rd_n = 1'b1;
  endtask

  task automatic test_basic_jump();
    arm(16'h1234, 1'b0, 1'b0);
    bus_read(1'b1, 1'b1);
    bus_read(1'b0, 1'b0);
    bus_read(1'b0, 1'b0);
  endtask

  task automatic test_prefix_skip();
    arm(16'h1234, 1'b0, 1'b0);
    bus_read(1'b1, 1'b0);
    bus_read(1'b1, 1'b1);
    bus_read(1'b0, 1'b0);
    bus_read(1'b0, 1'b0);
  endtask

  task automatic test_non_read_cycles();
    arm(16'h1234, 1'b0, 1'b0);
    bus_other(0);
    bus_other(2);
    bus_read(1'b1, 1'b1);
    bus_other(1);
    bus_read(1'b0, 1'b0);
    bus_other(0);
    bus_read(1'b0, 1'b0);
  endtask

  task automatic test_cancel();
    arm(16'h1234, 1'b0, 1'b0);
    cancel_req();
    bus_read(1'b1, 1'b1);
    arm(16'h5555, 1'b1, 1'b0);
    bus_read(1'b1, 1'b1);
    arm(16'h1234, 1'b0, 1'b0);
    bus_read(1'b1, 1'b1);
    cancel_req();
    bus_read(1'b0, 1'b0);
    bus_read(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_lo();
    arm(16'h1234, 1'b0, 1'b0);
    bus_read(1'b1, 1'b1);
    @(negedge clk);
    m1_n = 1'b1; mreq_n = 1'b0; rd_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (data_oe !== 1'b1 || data_out !== 8'h34) begin
      errors++;
      $display("FAIL pre_reset_drive got oe=%b dout=%h want 1 34", data_oe, data_out);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (data_oe !== 1'b0 || mem_inhibit !== 1'b0 || busy !== 1'b0 || data_out !== 8'h00) begin
      errors++;
      $display("FAIL async_reset got oe=%b inh=%b busy=%b dout=%h want 0 0 0 00",
               data_oe, mem_inhibit, busy, data_out);
    end
    @(negedge clk);
    rd_n = 1'b1; mreq_n = 1'b1;
    rst_n = 1'b1;
    m_armed = 1'b0; m_q.delete();
    bus_read(1'b0, 1'b0);
    bus_read(1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    arm(16'h1234, 1'b0, 1'b1);
    bus_read(1'b1, 1'b1);
    @(negedge clk);
    trap_vector = 16'hABCD;
    bus_read(1'b0, 1'b0);
    bus_read(1'b0, 1'b0);
    bus_read(1'b1, 1'b1);
    bus_read(1'b0, 1'b0);
    bus_read(1'b0, 1'b0);
    @(negedge clk);
    trap_req = 1'b0; m_hold = 1'b0;
    cancel_req();
  endtask

  task automatic test_random();
    int op;
    for (int n = 0; n < 80; n++) begin
      op = $urandom_range(0, 7);
      case (op)
        0: arm(16'($urandom), ($urandom_range(0, 5) == 0), 1'b0);
        1: cancel_req();
        2: bus_other($urandom_range(0, 2));
        3: bus_read(1'b1, 1'($urandom_range(0, 1)));
        default: bus_read(1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_basic_jump();
    test_prefix_skip();
    test_non_read_cycles();
    test_cancel();
    test_reset_mid_lo();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/opcode_injector.md
Name: opcode_injector

Overview:
- Transmit-side counterpart of the M1 opcode decoder: instead of watching opcodes the CPU fetches, it supplies opcodes to the CPU.
- On a trap request it waits for a clean instruction boundary, then drives a 3-byte `JP nn` (C3, lo, hi) onto the Z80 data bus over three consecutive memory reads.
- While driving, it inhibits the real memory, so the CPU jumps to the trap handler without NMI.
- Sits beside the decoder in the Nabu CPLD, between the Z80 bus and the mapper's memory-select logic.

Parameters:
- JP_OPCODE, 8'hC3, opcode byte driven in the first injected fetch.
- VECTOR_W, 16, width of the jump target.

Ports:
- clk  input  1  Z80 CPU clock; all bus inputs are sampled on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- m1_n  input  1  Z80 M1.
- mreq_n  input  1  Z80 MREQ.
- rd_n  input  1  Z80 RD.
- new_isr  input  1  from decoder: the next M1 fetch starts a new instruction.
- trap_req  input  1  level; request injection (sticky once sampled high).
- trap_cancel  input  1  drop a pending (not yet started) request.
- trap_vector  input  VECTOR_W  jump target, latched on arm.
- data_out  output  8  byte to drive on D[7:0].
- data_oe  output  1  drive enable for data_out.
- mem_inhibit  output  1  suppress RAM/ROM chip selects.
- busy  output  1  armed or injecting.
- inject_done  output  1  one-clk pulse after the high byte's cycle ends.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; data_out=8'h00; data_oe=0; mem_inhibit=0; busy=0; inject_done=0; vector register=0.
  - Outputs clear immediately, even mid-cycle.
- Bus-cycle detection:
  - rd_n is registered once (rd_q).
  - Read start: rd_n=0, rd_q=1, mreq_n=0.
  - Read end: rd_n=1, rd_q=0.
  - Refresh (mreq_n=0, rd_n=1) and interrupt-acknowledge (m1_n=0, mreq_n=1) are never read cycles.
- State machine:
  - IDLE: trap_req=1 -> ARMED; latch trap_vector; busy=1.
  - ARMED:
    - trap_cancel=1 -> IDLE.
    - Read start with m1_n=0 and new_isr=1 -> OP.
    - Read start with m1_n=0 and new_isr=0 (prefix/CB/ED second byte) -> stay ARMED, no drive.
  - OP: drive JP_OPCODE; read end -> LO.
  - LO: on the next read start with m1_n=1, drive vector[7:0]; read end -> HI.
  - HI: same rule, drive vector[15:8]; read end -> IDLE, inject_done=1 for one clk.
- Drive timing:
  - data_oe = mem_inhibit = (state in OP/LO/HI) AND cycle active (mreq_n=0, rd_n=0), combinational from bus pins.
  - Drive is asserted within the same cycle the read begins and released as RD rises.
  - data_out is stable for the whole state.
- Simultaneous and boundary events:
  - trap_cancel in OP/LO/HI is ignored; the 3-byte sequence always completes.
  - trap_req held high through completion re-arms on the clk after inject_done.
  - trap_req and trap_cancel both high in IDLE: cancel wins, stay IDLE.
  - trap_vector changes after arm are ignored.
  - A write cycle (wr) between injected reads does not advance state.
  - An M1 read start in LO/HI (should not occur) -> abort to IDLE, no drive, no inject_done.

Decomposition:
- Shared package z80_pkg:
  - Opcode constants: OP_JP=8'hC3, OP_PFX_CB=8'hCB, OP_PFX_ED=8'hED, OP_PFX_DD=8'hDD, OP_PFX_FD=8'hFD, OP_RETN2=8'h45.
  - Injector state encoding (IDLE, ARMED, OP, LO, HI).
  - The decoder adopts the same opcode constants.
- One sub-module: z80_cycle_detect (rd_q register; read_start/read_end/m1_read flags), reusable by other bus-snooping blocks.

Test Plan:
1. trap_req=1, vector=16'h1234. M1 read with new_isr=1, then two memory reads -> data_out C3, 34, 12 with data_oe/mem_inhibit high only while rd_n=0; inject_done pulses once; busy falls.
2. Armed; M1 read with new_isr=0 (after ED), then M1 with new_isr=1 -> first fetch not driven, C3 driven on the second.
3. Armed; refresh cycle (mreq_n=0, rd_n=1) and interrupt-ack M1 -> data_oe stays 0, state stays ARMED.
4. trap_cancel in ARMED -> IDLE, no drive. trap_cancel in LO -> sequence completes (34, 12).
5. rst_n low during LO with rd_n=0 -> data_oe and mem_inhibit drop asynchronously; after release, the next reads are not driven.
6. trap_req held high; vector changed to 16'hABCD mid-sequence -> first jump uses 1234; re-arm one clk after inject_done; next jump drives C3, CD, AB.
